seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the multi-digit 7-segment display. It drives one shared active-low segment decoder, feeding it the nibble, decimal point and latch-enable of one digit at a time. It also drives the per-digit active-low anode lines. Display values are double-buffered: a new value is captured on `load` and committed only at a frame boundary, so a digit never shows a partial update.

## Interface
- `DIGITS`, 4, number of multiplexed digits (2..8)
- `SCAN_DIV`, 100000, cycles each digit is lit per frame (≥1)
- `BLANK_CYC`, 8, dead cycles with all anodes off before each digit (≥1, anti-ghosting)

- `clk` in 1: system clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `data_in` in 4*DIGITS: nibble per digit; digit i = bits [4i+3:4i], digit 0 least significant
- `point_in` in DIGITS: decimal point request per digit
- `en_in` in DIGITS: digit enable per digit; 0 keeps the digit dark
- `load` in 1: one-cycle capture strobe for `data_in`/`point_in`/`en_in`
- `lz_sup` in 1: leading-zero suppression enable, sampled live
- `pending` out 1: captured value is waiting for commit
- `frame_done` out 1: one-cycle pulse at each frame boundary
- `an` out DIGITS: anode selects, active-low
- `dec_data` out 4: decoder nibble
- `dec_point` out 1: decoder point request, active-high
- `dec_LE` out 1: decoder enable; 0 means decoder outputs all segments off

## Operation
- Two buffers, each holding data, point and enable bits: pending (PB) and active (AB). Only AB is displayed.
- `load`=1: capture inputs into PB and set `pending`. A later `load` before commit overwrites PB; the last load wins.
- Commit happens at the frame boundary: if `pending`, PB is copied to AB and `pending` clears.
- If `load` and commit fall on the same cycle, the old PB is committed, the new inputs are captured into PB, and `pending` stays 1.
- FSM states: BLANK and SHOW. Index `idx` runs 0..DIGITS-1. Counter `cnt` has width $clog2(max(SCAN_DIV,BLANK_CYC)).
- BLANK: `an` all 1, `dec_LE`=0. `dec_data`/`dec_point` already hold AB digit `idx`. After BLANK_CYC cycles, go to SHOW with `cnt`=0.
- SHOW: `an[idx]`=0 and `dec_LE`=1 if digit `idx` is visible; otherwise `an` all 1 and `dec_LE`=0. After SCAN_DIV cycles, `idx` advances and the FSM goes to BLANK.
- Wrap: `idx` goes from DIGITS-1 to 0. This transition is the frame boundary: commit happens here and `frame_done` is asserted.
- Visible means AB enable[idx]=1 and the digit is not suppressed.
- Suppressed means `lz_sup`=1, idx≥1, and the AB nibbles idx..DIGITS-1 are all 0. Digit 0 is never suppressed. A suppressed digit shows no point either.
- At most one anode is low in any cycle.

## Timing
- Reset values: state=BLANK, idx=0, cnt=0, `an`=all 1, `dec_data`=0, `dec_point`=0, `dec_LE`=0, `pending`=0, `frame_done`=0. AB and PB are cleared to all 0, so the display is dark until the first commit.
- Cycle 0 is the first cycle with `rst` low. Digit k occupies cycles k·P .. k·P+P−1, where P=BLANK_CYC+SCAN_DIV. SHOW for digit k covers the last SCAN_DIV cycles of that window.
- All outputs are registered. `an`, `dec_LE`, `dec_data` and `dec_point` change only on BLANK/SHOW transitions.
- `frame_done` is high for exactly one cycle: the first BLANK cycle of digit 0, i.e. cycle F, 2F, …, where F=DIGITS·P.
- `pending` rises the cycle after `load`. It falls in the `frame_done` cycle unless a `load` occurred in the prior cycle.
- Committed data is displayed from digit 0 of the frame that begins at `frame_done`.
- Load-to-display latency: at most F+BLANK_CYC cycles.
- `rst` mid-frame: all state returns to reset values on the next edge, and any pending value is discarded.
- `lz_sup` toggling mid-frame takes effect at the next BLANK entry.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=4, BLANK_CYC=2, so P=6 and F=24.
- Reset, no load → `an`=4'b1111 and `dec_LE`=0 for 48 cycles; `frame_done` pulses at cycles 24 and 48; `pending`=0.
- Load data=16'h12A5, point=4'b0010, en=4'hF at cycle 3 → `pending`=1 from cycle 4 to 23. At cycle 24, `frame_done`=1 and `pending`=0.
  - Cycles 26–29: `an`=1110, `dec_data`=5, `dec_point`=0.
  - Cycles 32–35: `an`=1101, `dec_data`=A, `dec_point`=1.
  - Cycles 38–41: `an`=1011, `dec_data`=2.
  - Cycles 44–47: `an`=0111, `dec_data`=1.
  - BLANK cycles: `an`=1111 and `dec_LE`=0.
- Committed 16'h0070, `lz_sup`=1 → digits 3 and 2 stay dark (`an`=1111, `dec_LE`=0). Digit 1 shows 7. Digit 0 shows 0.
- Committed 16'h0000, `lz_sup`=1 → only digit 0 lit, showing 0.
- Load A at cycle 10, load B at cycle 15 → frame 2 displays B, and A is never shown.
- Load C at cycle 23 (the commit edge) with B pending → B is shown in frame 2 and C in frame 3; `pending` stays 1 through cycle 47.
- Pulse `rst` at cycle 30 → cycle 31 shows all reset values and AB=0. The timeline restarts from cycle 0 after `rst` falls.
- Load with en=4'b0101 → digits 1 and 3 stay dark in their SHOW windows; `an` never has two zeros in any cycle.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment scan controller with double-buffered display values
module seg_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     point_in,
   input  logic [DIGITS-1:0]     en_in,
   input  logic                  load,
   input  logic                  lz_sup,
   output logic                  pending,
   output logic                  frame_done,
   output logic [DIGITS-1:0]     an,
   output logic [3:0]            dec_data,
   output logic                  dec_point,
   output logic                  dec_LE
);

   localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int IW   = $clog2(DIGITS);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic                  vis_q;

   logic [4*DIGITS-1:0]   pb_d, ab_d;
   logic [DIGITS-1:0]     pb_p, ab_p;
   logic [DIGITS-1:0]     pb_e, ab_e;

   logic                  blank_end, show_end, wrap, commit;
   logic [IW-1:0]         idx_nx;
   logic [4*DIGITS-1:0]   ab_d_nx;
   logic [DIGITS-1:0]     ab_p_nx, ab_e_nx;
   logic [DIGITS-1:0]     tail_zero;
   logic                  supp_nx, vis_nx, run;

   assign blank_end = (state == BLANK) && (cnt == CW'(BLANK_CYC - 1));
   assign show_end  = (state == SHOW)  && (cnt == CW'(SCAN_DIV - 1));
   assign wrap      = show_end && (idx == IW'(DIGITS - 1));
   assign commit    = wrap && pending;
   assign idx_nx    = wrap ? '0 : idx + IW'(1);

   // Values the next BLANK window will see, including a commit on the same edge
   assign ab_d_nx   = commit ? pb_d : ab_d;
   assign ab_p_nx   = commit ? pb_p : ab_p;
   assign ab_e_nx   = commit ? pb_e : ab_e;

   always_comb begin
      tail_zero = '0;
      run       = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run          = run & (ab_d_nx[4*i +: 4] == 4'd0);
         tail_zero[i] = run;
      end
   end

   assign supp_nx = lz_sup && (idx_nx != '0) && tail_zero[idx_nx];
   assign vis_nx  = ab_e_nx[idx_nx] && !supp_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BLANK;
         cnt        <= '0;
         idx        <= '0;
         vis_q      <= 1'b0;
         pb_d       <= '0;
         pb_p       <= '0;
         pb_e       <= '0;
         ab_d       <= '0;
         ab_p       <= '0;
         ab_e       <= '0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
         an         <= '1;
         dec_data   <= 4'd0;
         dec_point  <= 1'b0;
         dec_LE     <= 1'b0;
      end else begin
         frame_done <= wrap;

         if (load) begin
            pb_d    <= data_in;
            pb_p    <= point_in;
            pb_e    <= en_in;
            pending <= 1'b1;
         end else if (wrap) begin
            pending <= 1'b0;
         end

         if (commit) begin
            ab_d <= pb_d;
            ab_p <= pb_p;
            ab_e <= pb_e;
         end

         case (state)
            BLANK: begin
               if (blank_end) begin
                  state  <= SHOW;
                  cnt    <= '0;
                  an     <= vis_q ? ~(DIGITS'(1) << idx) : '1;
                  dec_LE <= vis_q;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SHOW: begin
               if (show_end) begin
                  // Decoder inputs settle during the dark window before the anode turns on
                  state     <= BLANK;
                  cnt       <= '0;
                  idx       <= idx_nx;
                  an        <= '1;
                  dec_LE    <= 1'b0;
                  dec_data  <= ab_d_nx[{idx_nx, 2'b00} +: 4];
                  dec_point <= ab_p_nx[idx_nx] && !supp_nx;
                  vis_q     <= vis_nx;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= BLANK;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed table-driven bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] data_in = '0;
   logic [3:0]  point_in = '0;
   logic [3:0]  en_in = '0;
   logic        load = 1'b0;
   logic        lz_sup = 1'b0;
   logic        pending, frame_done, dec_point, dec_LE;
   logic [3:0]  an, dec_data;

   seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(2)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .point_in(point_in), .en_in(en_in),
      .load(load), .lz_sup(lz_sup), .pending(pending), .frame_done(frame_done),
      .an(an), .dec_data(dec_data), .dec_point(dec_point), .dec_LE(dec_LE)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          sc;
      int          cyc;
      logic [15:0] d;
      logic [3:0]  p;
      logic [3:0]  e;
   } load_t;

   typedef struct {
      int          sc;
      int          cyc;
      logic [3:0]  an;
      logic        le;
      logic [3:0]  data;
      logic        pt;
      logic        pend;
   } exp_t;

   load_t loads[$];
   exp_t  exps[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    cur   = 0;
   int    cur_sc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s sc=%0d cyc=%0d actual=%h required=%h", nm, cur_sc, cur, act, req);
      end
   endtask

   task automatic add_l(input int sc, input int cyc, input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
      load_t l;
      l.sc = sc; l.cyc = cyc; l.d = d; l.p = p; l.e = e;
      loads.push_back(l);
   endtask

   task automatic add_e(input int sc, input int cyc, input logic [3:0] a, input logic le,
                        input logic [3:0] d, input logic pt, input logic pend);
      exp_t x;
      x.sc = sc; x.cyc = cyc; x.an = a; x.le = le; x.data = d; x.pt = pt; x.pend = pend;
      exps.push_back(x);
   endtask

   task automatic run_sc(input int sc, input int ncyc, input logic lz, input int rst_at);
      int base;
      int rel;
      cur_sc = sc;
      rst = 1'b1; load = 1'b0; lz_sup = lz;
      data_in = '0; point_in = '0; en_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      base = 0;
      for (int c = 0; c < ncyc; c++) begin
         cur  = c;
         load = 1'b0;
         rst  = (c == rst_at);
         foreach (loads[i]) begin
            if (loads[i].sc == sc && loads[i].cyc == c) begin
               load = 1'b1; data_in = loads[i].d; point_in = loads[i].p; en_in = loads[i].e;
            end
         end
         @(negedge clk);
         rel = c - base;
         chk("one_anode", 32'($countones(~an) <= 1), 32'd1);
         chk("frame_done", 32'(frame_done), 32'((rel > 0) && (rel % 24 == 0)));
         if (rel % 6 < 2)
            chk("blank_dark", {27'd0, an, dec_LE}, {27'd0, 4'b1111, 1'b0});
         foreach (exps[i]) begin
            if (exps[i].sc == sc && exps[i].cyc == c) begin
               chk("an_le_pend", {26'd0, an, dec_LE, pending}, {26'd0, exps[i].an, exps[i].le, exps[i].pend});
               chk("data_point", {27'd0, dec_data, dec_point}, {27'd0, exps[i].data, exps[i].pt});
            end
         end
         if (c == rst_at) base = c + 1;
         @(posedge clk);
         #1;
      end
      load = 1'b0;
   endtask

   initial begin
      // sc0: idle after reset
      add_e(0, 0, 4'b1111, 0, 4'h0, 0, 0);
      add_e(0, 10, 4'b1111, 0, 4'h0, 0, 0);
      add_e(0, 26, 4'b1111, 0, 4'h0, 0, 0);
      add_e(0, 48, 4'b1111, 0, 4'h0, 0, 0);
      // sc1: 12A5, point on digit 1
      add_l(1, 3, 16'h12A5, 4'b0010, 4'hF);
      add_e(1, 3, 4'b1111, 0, 4'h0, 0, 0);
      add_e(1, 4, 4'b1111, 0, 4'h0, 0, 1);
      add_e(1, 23, 4'b1111, 0, 4'h0, 0, 1);
      add_e(1, 24, 4'b1111, 0, 4'h5, 0, 0);
      add_e(1, 26, 4'b1110, 1, 4'h5, 0, 0);
      add_e(1, 29, 4'b1110, 1, 4'h5, 0, 0);
      add_e(1, 30, 4'b1111, 0, 4'hA, 1, 0);
      add_e(1, 32, 4'b1101, 1, 4'hA, 1, 0);
      add_e(1, 35, 4'b1101, 1, 4'hA, 1, 0);
      add_e(1, 38, 4'b1011, 1, 4'h2, 0, 0);
      add_e(1, 41, 4'b1011, 1, 4'h2, 0, 0);
      add_e(1, 44, 4'b0111, 1, 4'h1, 0, 0);
      add_e(1, 47, 4'b0111, 1, 4'h1, 0, 0);
      add_e(1, 48, 4'b1111, 0, 4'h5, 0, 0);
      // sc2: 0070 with leading-zero suppression
      add_l(2, 3, 16'h0070, 4'b0000, 4'hF);
      add_e(2, 26, 4'b1110, 1, 4'h0, 0, 0);
      add_e(2, 32, 4'b1101, 1, 4'h7, 0, 0);
      add_e(2, 38, 4'b1111, 0, 4'h0, 0, 0);
      add_e(2, 44, 4'b1111, 0, 4'h0, 0, 0);
      // sc3: all zero, suppressed digits lose their points too
      add_l(3, 3, 16'h0000, 4'b1111, 4'hF);
      add_e(3, 26, 4'b1110, 1, 4'h0, 1, 0);
      add_e(3, 32, 4'b1111, 0, 4'h0, 0, 0);
      add_e(3, 38, 4'b1111, 0, 4'h0, 0, 0);
      add_e(3, 44, 4'b1111, 0, 4'h0, 0, 0);
      // sc4: last load wins
      add_l(4, 10, 16'h3333, 4'b0000, 4'hF);
      add_l(4, 15, 16'h4567, 4'b0000, 4'hF);
      add_e(4, 11, 4'b1111, 0, 4'h0, 0, 1);
      add_e(4, 16, 4'b1111, 0, 4'h0, 0, 1);
      add_e(4, 24, 4'b1111, 0, 4'h7, 0, 0);
      add_e(4, 26, 4'b1110, 1, 4'h7, 0, 0);
      add_e(4, 32, 4'b1101, 1, 4'h6, 0, 0);
      add_e(4, 38, 4'b1011, 1, 4'h5, 0, 0);
      add_e(4, 44, 4'b0111, 1, 4'h4, 0, 0);
      // sc5: load on the commit edge
      add_l(5, 10, 16'h4567, 4'b0000, 4'hF);
      add_l(5, 23, 16'h89AB, 4'b0000, 4'hF);
      add_e(5, 24, 4'b1111, 0, 4'h7, 0, 1);
      add_e(5, 26, 4'b1110, 1, 4'h7, 0, 1);
      add_e(5, 32, 4'b1101, 1, 4'h6, 0, 1);
      add_e(5, 38, 4'b1011, 1, 4'h5, 0, 1);
      add_e(5, 44, 4'b0111, 1, 4'h4, 0, 1);
      add_e(5, 47, 4'b0111, 1, 4'h4, 0, 1);
      add_e(5, 48, 4'b1111, 0, 4'hB, 0, 0);
      add_e(5, 50, 4'b1110, 1, 4'hB, 0, 0);
      add_e(5, 56, 4'b1101, 1, 4'hA, 0, 0);
      add_e(5, 62, 4'b1011, 1, 4'h9, 0, 0);
      add_e(5, 68, 4'b0111, 1, 4'h8, 0, 0);
      // sc6: reset mid-frame discards pending and clears the display
      add_l(6, 3, 16'h12A5, 4'b0010, 4'hF);
      add_l(6, 28, 16'h9999, 4'b0000, 4'hF);
      add_e(6, 29, 4'b1110, 1, 4'h5, 0, 1);
      add_e(6, 31, 4'b1111, 0, 4'h0, 0, 0);
      add_e(6, 33, 4'b1111, 0, 4'h0, 0, 0);
      add_e(6, 55, 4'b1111, 0, 4'h0, 0, 0);
      add_e(6, 57, 4'b1111, 0, 4'h0, 0, 0);
      // sc7: partial enables
      add_l(7, 3, 16'h1234, 4'b0000, 4'b0101);
      add_e(7, 26, 4'b1110, 1, 4'h4, 0, 0);
      add_e(7, 32, 4'b1111, 0, 4'h3, 0, 0);
      add_e(7, 38, 4'b1011, 1, 4'h2, 0, 0);
      add_e(7, 44, 4'b1111, 0, 4'h1, 0, 0);

      run_sc(0, 50, 1'b0, -1);
      run_sc(1, 50, 1'b0, -1);
      run_sc(2, 48, 1'b1, -1);
      run_sc(3, 48, 1'b1, -1);
      run_sc(4, 48, 1'b0, -1);
      run_sc(5, 72, 1'b0, -1);
      run_sc(6, 60, 1'b0, 30);
      run_sc(7, 48, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
